// File: rtl/cnn_pkg.sv
// Shared constants for the window/byte bridges of the convolution path.
// The idx width helper lets every block size its byte index from a byte count.
package cnn_pkg;

   localparam int PIXEL_W   = 8;
   localparam int WIN_BYTES = 9;
   localparam int VEC_W     = PIXEL_W * WIN_BYTES;

   // Width of a byte index that counts 0..n-1 (never narrower than one bit).
   function automatic int idx_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

   localparam int IDX_W = idx_width(WIN_BYTES);

endpackage

// File: rtl/vector_serializer.sv
// vector_serializer: takes one packed window per valid/ready handshake and
// emits it as a byte stream, lowest byte first, one byte per cycle.
// A one-deep hold register parks the next vector while the current one
// shifts out, so back-to-back vectors leave no idle cycle on the byte side.
// Optional build macro VSER_LAST_EN adds m_axis_last, marking the final byte
// of each vector.
//
// The controller is implicit in the two flags hold_valid and m_axis_valid:
//   state      | meaning
//   EMPTY      | no vector held, nothing being sent
//   HOLD       | vector parked, output idle (loads on the next edge)
//   SEND       | vector shifting out, hold register free
//   SEND+HOLD  | vector shifting out, next vector parked
module vector_serializer
   import cnn_pkg::*;
#(
   parameter int N_BYTES = WIN_BYTES,
   parameter int BYTE_W  = PIXEL_W
) (
   input  logic                        clk,
   input  logic                        rst_n,
   input  logic [N_BYTES*BYTE_W-1:0]   s_vector,
   input  logic                        s_vector_valid,
   output logic                        s_vector_ready,
   output logic [BYTE_W-1:0]           m_axis_data,
   output logic                        m_axis_valid,
   input  logic                        m_axis_ready,
   output logic                        busy,
   output logic [15:0]                 vector_count
`ifdef VSER_LAST_EN
   ,
   output logic                        m_axis_last
`endif
);

   localparam int              VEC_BITS = N_BYTES * BYTE_W;
   localparam int              IW       = idx_width(N_BYTES);
   localparam logic [IW-1:0]   LAST_IDX = IW'(N_BYTES - 1);

   logic [VEC_BITS-1:0] hold_q;
   logic                hold_valid;
   logic [VEC_BITS-1:0] shift_q;
   logic [IW-1:0]       idx_q;

   logic accept;
   logic byte_hs;
   logic last_hs;
   logic load;

   // Ready depends on the hold flag only, so no combinational path reaches it.
   assign s_vector_ready = !hold_valid;
   assign m_axis_data    = shift_q[BYTE_W-1:0];
   assign busy           = hold_valid | m_axis_valid;

`ifdef VSER_LAST_EN
   // Last-byte marker follows the index; zero whenever no byte is offered.
   assign m_axis_last = m_axis_valid && (idx_q == LAST_IDX);
`endif

   // Handshake strobes. Accept and load are mutually exclusive because
   // accept needs an empty hold and load needs a full one.
   always_comb begin
      accept  = 1'b0;
      byte_hs = 1'b0;
      last_hs = 1'b0;
      load    = 1'b0;
      accept  = s_vector_valid && !hold_valid;
      byte_hs = m_axis_valid && m_axis_ready;
      last_hs = byte_hs && (idx_q == LAST_IDX);
      load    = hold_valid && (!m_axis_valid || last_hs);
   end

   // Hold stage: capture a vector on accept, release it when it loads.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         hold_q     <= '0;
         hold_valid <= 1'b0;
      end else if (accept) begin
         hold_q     <= s_vector;
         hold_valid <= 1'b1;
      end else if (load) begin
         hold_valid <= 1'b0;
      end
   end

   // Shift stage: load a new vector, advance on each byte handshake, and
   // drop valid after the last byte unless a parked vector takes over.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         shift_q      <= '0;
         idx_q        <= '0;
         m_axis_valid <= 1'b0;
      end else if (load) begin
         shift_q      <= hold_q;
         idx_q        <= '0;
         m_axis_valid <= 1'b1;
      end else if (last_hs) begin
         m_axis_valid <= 1'b0;
      end else if (byte_hs) begin
         shift_q      <= shift_q >> BYTE_W;
         idx_q        <= idx_q + IW'(1);
      end
   end

   // Completed-vector counter, wrapping at 16 bits.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         vector_count <= '0;
      end else if (last_hs) begin
         vector_count <= vector_count + 16'd1;
      end
   end

endmodule

// File: tb/tb_vector_serializer.sv
// Bench for vector_serializer: directed scenarios with literal expectations
// plus a randomized run, all checked every cycle against a stream-level model
// (byte FIFO, parked-vector flag, bytes left in the current vector).
module tb_vector_serializer;
   import cnn_pkg::*;

   localparam int N  = WIN_BYTES;
   localparam int BW = PIXEL_W;
   localparam int VW = N * BW;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic [VW-1:0] s_vector = '0;
   logic          s_vector_valid = 1'b0;
   logic          s_vector_ready;
   logic [BW-1:0] m_axis_data;
   logic          m_axis_valid;
   logic          m_axis_ready = 1'b0;
   logic          busy;
   logic [15:0]   vector_count;
`ifdef VSER_LAST_EN
   logic          m_axis_last;
`endif

   int tests = 0;
   int fails = 0;

   // model state
   logic [BW-1:0] exp_q[$];
   bit            parked = 0;
   int            left   = 0;
   int            done   = 0;
   int            cyc    = 0;
   int            acc_cyc[$];
   int            hs_cyc[$];
   logic [BW-1:0] hs_byte[$];

   always #5 clk = ~clk;

   vector_serializer dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .s_vector       (s_vector),
      .s_vector_valid (s_vector_valid),
      .s_vector_ready (s_vector_ready),
      .m_axis_data    (m_axis_data),
      .m_axis_valid   (m_axis_valid),
      .m_axis_ready   (m_axis_ready),
      .busy           (busy),
      .vector_count   (vector_count)
`ifdef VSER_LAST_EN
      ,
      .m_axis_last    (m_axis_last)
`endif
   );

   function automatic void chk(input string nm, input longint act, input longint exp);
      tests++;
      if (act != exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
      end
   endfunction

   function automatic logic [VW-1:0] mk_vec(input int base);
      logic [VW-1:0] v;
      v = '0;
      for (int k = 0; k < N; k++) v[k*BW +: BW] = BW'(base + k);
      return v;
   endfunction

   // Per-cycle compare against the model, then advance the model across the
   // coming rising edge using the inputs that will be sampled there.
   always @(negedge clk) begin
      bit in_hs, out_hs, was_parked;
      int old_left;
      cyc++;
      if (!rst_n) begin
         chk("rst_valid", m_axis_valid, 0);
         chk("rst_data", m_axis_data, 0);
         chk("rst_count", vector_count, 0);
         chk("rst_busy", busy, 0);
         chk("rst_ready", s_vector_ready, 1);
`ifdef VSER_LAST_EN
         chk("rst_last", m_axis_last, 0);
`endif
         exp_q.delete();
         parked = 0;
         left   = 0;
         done   = 0;
      end else begin
         chk("ready", s_vector_ready, !parked);
         chk("valid", m_axis_valid, left > 0);
         chk("busy", busy, parked || left > 0);
         chk("count", vector_count, done % 65536);
         if (left > 0) chk("data", m_axis_data, exp_q.size() > 0 ? longint'(exp_q[0]) : -1);
`ifdef VSER_LAST_EN
         chk("last", m_axis_last, left == 1);
`endif
         was_parked = parked;
         old_left   = left;
         in_hs      = s_vector_valid && !parked;
         out_hs     = (left > 0) && m_axis_ready;
         if (out_hs && exp_q.size() > 0) begin
            hs_cyc.push_back(cyc);
            hs_byte.push_back(exp_q.pop_front());
            left--;
            if (left == 0) done++;
         end
         if (was_parked && (old_left == 0 || (out_hs && old_left == 1))) begin
            left   = N;
            parked = 0;
         end
         if (in_hs) begin
            for (int k = 0; k < N; k++) exp_q.push_back(s_vector[k*BW +: BW]);
            parked = 1;
            acc_cyc.push_back(cyc);
         end
      end
   end

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic clear_logs();
      acc_cyc.delete();
      hs_cyc.delete();
      hs_byte.delete();
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      s_vector_valid = 1'b0;
      tick(3);
      rst_n = 1'b1;
      tick(1);
      clear_logs();
   endtask

   task automatic send_vec(input logic [VW-1:0] v);
      int   n;
      logic rdy;
      n = 0;
      s_vector = v;
      s_vector_valid = 1'b1;
      do begin
         rdy = s_vector_ready;
         @(posedge clk);
         #1;
         n++;
      end while (!rdy && n < 200);
      s_vector_valid = 1'b0;
      chk("accept_timeout", rdy, 1);
   endtask

   task automatic wait_idle();
      int n;
      n = 0;
      while (busy && n < 1000) begin
         tick(1);
         n++;
      end
      chk("idle_timeout", busy, 0);
   endtask

   task automatic wait_byte(input logic [BW-1:0] b);
      int n;
      n = 0;
      while (!(m_axis_valid && m_axis_data == b) && n < 100) begin
         tick(1);
         n++;
      end
      chk("byte_wait_timeout", m_axis_valid && m_axis_data == b, 1);
   endtask

   // Checks that the logged bytes are base, base+1, ... for cnt entries.
   task automatic check_seq(input string nm, input int base, input int cnt);
      chk({nm, "_len"}, hs_byte.size(), cnt);
      for (int i = 0; i < cnt && i < hs_byte.size(); i++)
         chk({nm, "_byte"}, hs_byte[i], (base + i) % 256);
   endtask

   initial begin
      #1ms;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int gap_ok;

      // Single vector, ready high.
      do_reset();
      m_axis_ready = 1'b1;
      send_vec(72'h090807060504030201);
      wait_idle();
      check_seq("single", 1, 9);
      if (acc_cyc.size() > 0 && hs_cyc.size() > 0)
         chk("single_latency", hs_cyc[0] - acc_cyc[0], 2);
      else
         chk("single_latency_missing", 0, 1);
      gap_ok = 1;
      for (int i = 1; i < hs_cyc.size(); i++)
         if (hs_cyc[i] != hs_cyc[i-1] + 1) gap_ok = 0;
      chk("single_gapless", gap_ok, 1);
      chk("single_count", vector_count, 1);
      chk("single_valid_low", m_axis_valid, 0);

      // Two vectors back-to-back.
      do_reset();
      m_axis_ready = 1'b1;
      send_vec(mk_vec(1));
      send_vec(72'h1211100F0E0D0C0B0A);
      wait_idle();
      check_seq("b2b", 1, 18);
      gap_ok = 1;
      for (int i = 1; i < hs_cyc.size(); i++)
         if (hs_cyc[i] != hs_cyc[i-1] + 1) gap_ok = 0;
      chk("b2b_gapless", gap_ok, 1);
      chk("b2b_count", vector_count, 2);

      // Backpressure while byte 03 is offered.
      do_reset();
      m_axis_ready = 1'b1;
      send_vec(mk_vec(1));
      wait_byte(8'h03);
      m_axis_ready = 1'b0;
      tick(1);
      chk("stall_data1", m_axis_data, 8'h03);
      tick(1);
      chk("stall_data2", m_axis_data, 8'h03);
      m_axis_ready = 1'b1;
      wait_idle();
      check_seq("stall", 1, 9);
      if (hs_cyc.size() >= 3) chk("stall_hold_cycles", hs_cyc[2] - hs_cyc[1], 3);
      else chk("stall_hold_missing", 0, 1);

      // Downstream blocked, hold full, third vector refused until load.
      do_reset();
      m_axis_ready = 1'b0;
      send_vec(mk_vec(1));
      send_vec(mk_vec(10));
      s_vector = mk_vec(19);
      s_vector_valid = 1'b1;
      for (int i = 0; i < 3; i++) begin
         tick(1);
         chk("bp_ready_low", s_vector_ready, 0);
         chk("bp_busy", busy, 1);
         chk("bp_data_held", m_axis_data, 8'h01);
      end
      m_axis_ready = 1'b1;
      begin
         int   n;
         logic rdy;
         n = 0;
         do begin
            rdy = s_vector_ready;
            tick(1);
            n++;
         end while (!rdy && n < 100);
         s_vector_valid = 1'b0;
         chk("bp_third_accept", rdy, 1);
      end
      wait_idle();
      check_seq("bp", 1, 27);
      if (acc_cyc.size() == 3 && hs_cyc.size() >= 9)
         chk("bp_ready_rise", acc_cyc[2] - hs_cyc[8], 1);
      else
         chk("bp_accept_log", acc_cyc.size(), 3);
      chk("bp_count", vector_count, 3);

      // Reset mid-vector.
      do_reset();
      m_axis_ready = 1'b1;
      send_vec(mk_vec(1));
      wait_idle();
      chk("prerst_count", vector_count, 1);
      send_vec(mk_vec(1));
      wait_byte(8'h05);
      rst_n = 1'b0;
      #1;
      chk("midrst_valid", m_axis_valid, 0);
      chk("midrst_data", m_axis_data, 0);
      chk("midrst_count", vector_count, 0);
      chk("midrst_busy", busy, 0);
      chk("midrst_ready", s_vector_ready, 1);
      clear_logs();
      tick(3);
      chk("midrst_no_bytes", hs_byte.size(), 0);
      rst_n = 1'b1;
      tick(1);
      send_vec(mk_vec(8'h21));
      wait_idle();
      check_seq("postrst", 8'h21, 9);
      chk("postrst_count", vector_count, 1);

      // Randomized traffic; the per-cycle model does the checking.
      do_reset();
      for (int c = 0; c < 4000; c++) begin
         logic rdy;
         rdy = s_vector_ready;
         @(posedge clk);
         #1;
         if (s_vector_valid && rdy) s_vector_valid = 1'b0;
         if (!s_vector_valid && ($urandom % 3) != 0) begin
            for (int k = 0; k < N; k++) s_vector[k*BW +: BW] = BW'($urandom);
            s_vector_valid = 1'b1;
         end
         m_axis_ready = (c % 500 < 60) ? 1'b0 : (($urandom % 4) != 0);
      end
      begin
         int   n;
         logic rdy;
         n = 0;
         m_axis_ready = 1'b1;
         while (s_vector_valid && n < 100) begin
            rdy = s_vector_ready;
            tick(1);
            if (rdy) s_vector_valid = 1'b0;
            n++;
         end
         chk("rand_drain_accept", s_vector_valid, 0);
      end
      wait_idle();
      chk("rand_model_empty", exp_q.size(), 0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
